// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, load encodings and response FSM states for mem_stage
package mem_stage_pkg;

  // Bus widths of the EX->MEM, MEM->WB and MEM->ID bypass buses
  localparam int EX_BUS_W = 142;
  localparam int WB_BUS_W = 136;
  localparam int RF_BUS_W = 104;

  // Stall bus bit positions
  localparam int STALL_EX_MEM = 3;
  localparam int STALL_MEM_WB = 4;

  // Load kind encodings carried alongside the EX bus; 101-111 fall back to lw
  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  // Load response tracking states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HAVE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_stage_load_ext.sv
// rtl/mem_stage_load_ext.sv - little-endian byte/halfword/word extraction and extension
module load_ext
  import mem_stage_pkg::*;
(
  input  logic [2:0]  i_ld_op,
  input  logic [31:0] i_raw,
  input  logic [1:0]  i_addr,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed byte lane and halfword; addr[0] is ignored for halfwords
  always_comb begin
    w_byte = 8'h00;
    case (i_addr)
      2'd0:    w_byte = i_raw[7:0];
      2'd1:    w_byte = i_raw[15:8];
      2'd2:    w_byte = i_raw[23:16];
      default: w_byte = i_raw[31:24];
    endcase
    w_half = i_addr[1] ? i_raw[31:16] : i_raw[15:0];
  end

  // Extend by load kind; unknown encodings behave as a full-word load
  always_comb begin
    o_data = i_raw;
    case (i_ld_op)
      LD_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      LD_LBU:  o_data = {24'h000000, w_byte};
      LD_LH:   o_data = {{16{w_half[15]}}, w_half};
      LD_LHU:  o_data = {16'h0000, w_half};
      default: o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: stage register, load response FSM, result buses
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int EX_TO_MEM_WD = EX_BUS_W,
  parameter int MEM_TO_WB_WD = WB_BUS_W,
  parameter int MEM_TO_RF_WD = RF_BUS_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [2:0]              ld_op,
  input  logic [31:0]             data_sram_rdata,
  input  logic                    data_sram_rvalid,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus,
  output logic                    stallreq_for_mem
);

  logic [EX_TO_MEM_WD-1:0] r_bus;
  logic [2:0]              r_ld_op;
  mem_state_e              r_state;
  logic [31:0]             r_buf;

  logic        w_hold;
  logic        w_bubble;
  logic        w_advance;
  logic        w_is_load;
  logic [31:0] w_raw;
  logic [31:0] w_load_data;
  logic [31:0] w_rf_wdata;
  logic        w_unused_stall;

  // Only the EX/MEM and MEM/WB hold bits concern this stage
  assign w_unused_stall = ^{stall[5], stall[2:0]};

  assign w_hold    = stall[STALL_EX_MEM] & stall[STALL_MEM_WB];
  assign w_bubble  = stall[STALL_EX_MEM] & ~stall[STALL_MEM_WB];
  assign w_advance = ~w_hold;

  // Stage register: bubble when EX stops but WB keeps going, load when EX runs, else hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus   <= '0;
      r_ld_op <= 3'b000;
    end else if (w_bubble) begin
      r_bus   <= '0;
      r_ld_op <= 3'b000;
    end else if (!stall[STALL_EX_MEM]) begin
      r_bus   <= ex_to_mem_bus;
      r_ld_op <= ld_op;
    end
  end

  // A load reads memory without writing any byte lane
  assign w_is_load = r_bus[43] & (r_bus[42:39] == 4'b0000);

  // Response FSM: track the outstanding read and keep its data while MEM is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_buf   <= 32'h0;
    end else if (w_advance) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_load) begin
            if (data_sram_rvalid) begin
              r_state <= ST_HAVE;
              r_buf   <= data_sram_rdata;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (data_sram_rvalid) begin
            r_state <= ST_HAVE;
            r_buf   <= data_sram_rdata;
          end
        end
        ST_HAVE: r_state <= ST_HAVE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The response cycle itself completes the load, so stall drops with rvalid
  assign stallreq_for_mem = w_is_load & (r_state != ST_HAVE) & ~data_sram_rvalid;

  assign w_raw = ((r_state != ST_HAVE) && data_sram_rvalid) ? data_sram_rdata : r_buf;

  load_ext u_load_ext (
    .i_ld_op (r_ld_op),
    .i_raw   (w_raw),
    .i_addr  (r_bus[1:0]),
    .o_data  (w_load_data)
  );

  assign w_rf_wdata = r_bus[38] ? w_load_data : r_bus[31:0];

  assign mem_to_wb_bus = {r_bus[141:76], r_bus[75:44], r_bus[37], r_bus[36:32], w_rf_wdata};
  assign mem_to_rf_bus = {r_bus[141:76], r_bus[37], r_bus[36:32], w_rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage
module tb_mem_stage;

  logic         clk;
  logic         rst;
  logic [5:0]   stall;
  logic [141:0] ex_to_mem_bus;
  logic [2:0]   ld_op;
  logic [31:0]  data_sram_rdata;
  logic         data_sram_rvalid;
  logic [135:0] mem_to_wb_bus;
  logic [103:0] mem_to_rf_bus;
  logic         stallreq_for_mem;

  int n_checks;
  int n_errors;

  localparam logic [5:0] STALL_NONE   = 6'b000000;
  localparam logic [5:0] STALL_MEM    = 6'b011111;
  localparam logic [5:0] STALL_BUBBLE = 6'b001111;

  mem_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .ex_to_mem_bus    (ex_to_mem_bus),
    .ld_op            (ld_op),
    .data_sram_rdata  (data_sram_rdata),
    .data_sram_rvalid (data_sram_rvalid),
    .mem_to_wb_bus    (mem_to_wb_bus),
    .mem_to_rf_bus    (mem_to_rf_bus),
    .stallreq_for_mem (stallreq_for_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [135:0] act, input logic [135:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference extraction: shift the addressed unit down, mask, then extend arithmetically
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] raw,
                                           input logic [1:0] addr);
    logic [31:0] v;
    int          sh;
    case (op)
      3'd1, 3'd2: begin
        sh = 8 * int'(addr);
        v  = (raw >> sh) & 32'h0000_00FF;
        if (op == 3'd1 && v >= 32'h80) v = v + 32'hFFFF_FF00;
      end
      3'd3, 3'd4: begin
        sh = 16 * (int'(addr) / 2);
        v  = (raw >> sh) & 32'h0000_FFFF;
        if (op == 3'd3 && v >= 32'h8000) v = v + 32'hFFFF_0000;
      end
      default: v = raw;
    endcase
    return v;
  endfunction

  // Push one instruction through MEM: lat cycles until rvalid, then hold cycles of downstream stall
  task automatic run_instr(input string tag, input logic [65:0] hilo, input logic [31:0] pc,
                           input logic en, input logic [3:0] wen, input logic sel,
                           input logic we, input logic [4:0] waddr, input logic [31:0] res,
                           input logic [2:0] op, input logic [31:0] rdata,
                           input int lat, input int hold);
    logic         is_load;
    logic [31:0]  exp_wdata;
    logic [135:0] exp_wb;
    logic [103:0] exp_rf;
    int           n_lat;
    is_load   = en && (wen == 4'b0000);
    n_lat     = is_load ? lat : 0;
    exp_wdata = sel ? ref_load(op, rdata, res[1:0]) : res;
    exp_wb    = {hilo, pc, we, waddr, exp_wdata};
    exp_rf    = {hilo, we, waddr, exp_wdata};

    ex_to_mem_bus    = {hilo, pc, en, wen, sel, we, waddr, res};
    ld_op            = op;
    stall            = STALL_NONE;
    data_sram_rvalid = 1'b0;
    for (int c = 0; c <= n_lat; c++) begin
      @(posedge clk);
      #1;
      if (c == n_lat) begin
        data_sram_rvalid = 1'b1;
        data_sram_rdata  = is_load ? rdata : $urandom;
      end else begin
        data_sram_rvalid = 1'b0;
        data_sram_rdata  = $urandom;
      end
      @(negedge clk);
      chk({tag, "_stall"}, {135'd0, stallreq_for_mem}, {135'd0, (c < n_lat)});
      if (c == n_lat) begin
        chk({tag, "_wb"}, mem_to_wb_bus, exp_wb);
        chk({tag, "_rf"}, {32'd0, mem_to_rf_bus}, {32'd0, exp_rf});
      end else begin
        stall = STALL_MEM;
      end
    end
    for (int h = 0; h < hold; h++) begin
      stall = STALL_MEM;
      @(posedge clk);
      #1;
      data_sram_rvalid = 1'b1;
      data_sram_rdata  = ~rdata;
      @(negedge clk);
      chk({tag, "_hold_stall"}, {135'd0, stallreq_for_mem}, 136'd0);
      chk({tag, "_hold_wb"}, mem_to_wb_bus, exp_wb);
    end
  endtask

  initial begin
    logic [65:0] hilo;
    logic [31:0] res;
    int          kind;
    n_checks         = 0;
    n_errors         = 0;
    rst              = 1'b1;
    stall            = STALL_NONE;
    ex_to_mem_bus    = '0;
    ld_op            = 3'b000;
    data_sram_rdata  = 32'h0;
    data_sram_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", {135'd0, stallreq_for_mem}, 136'd0);
    chk("reset_wb", mem_to_wb_bus, 136'd0);
    chk("reset_rf", {32'd0, mem_to_rf_bus}, 136'd0);
    rst = 1'b0;

    hilo = {2'b10, 32'h1234_5678, 32'h9ABC_DEF0};
    run_instr("fast_lw", hilo, 32'hBFC0_0000, 1'b1, 4'h0, 1'b1, 1'b1, 5'd3,
              32'h0000_0100, 3'd0, 32'h8899_AABB, 0, 0);
    run_instr("slow_lb", hilo, 32'hBFC0_0004, 1'b1, 4'h0, 1'b1, 1'b1, 5'd4,
              32'h0000_0103, 3'd1, 32'h8011_2233, 3, 0);
    run_instr("lhu_up", hilo, 32'hBFC0_0008, 1'b1, 4'h0, 1'b1, 1'b1, 5'd5,
              32'h0000_0102, 3'd4, 32'hF00D_1234, 0, 0);
    run_instr("lh_up", hilo, 32'hBFC0_000C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6,
              32'h0000_0102, 3'd3, 32'hF00D_1234, 1, 0);
    run_instr("backpr", hilo, 32'hBFC0_0010, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7,
              32'h0000_0200, 3'd0, 32'hCAFE_BABE, 1, 2);
    run_instr("after_bp", hilo, 32'hBFC0_0014, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8,
              32'h0000_0201, 3'd2, 32'h0000_C300, 2, 0);

    // Bubble: EX stops while WB runs, MEM must carry nothing
    ex_to_mem_bus    = {hilo, 32'hBFC0_0018, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'h1111_2222};
    ld_op            = 3'b000;
    stall            = STALL_NONE;
    data_sram_rvalid = 1'b0;
    @(posedge clk);
    #1;
    stall = STALL_BUBBLE;
    @(posedge clk);
    #1;
    stall = STALL_NONE;
    @(negedge clk);
    chk("bubble_wb", mem_to_wb_bus, 136'd0);
    chk("bubble_rf", {32'd0, mem_to_rf_bus}, 136'd0);

    run_instr("sw_stray", hilo, 32'hBFC0_001C, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0,
              32'h0000_0300, 3'd0, 32'hDEAD_BEEF, 0, 0);

    // Asynchronous reset while a load waits
    ex_to_mem_bus    = {hilo, 32'hBFC0_0020, 1'b1, 4'h0, 1'b1, 1'b1, 5'd10, 32'h0000_0400};
    ld_op            = 3'b000;
    stall            = STALL_NONE;
    data_sram_rvalid = 1'b0;
    @(posedge clk);
    #1;
    stall = STALL_MEM;
    @(posedge clk);
    #1;
    chk("wait_stall", {135'd0, stallreq_for_mem}, 136'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_stall", {135'd0, stallreq_for_mem}, 136'd0);
    chk("arst_wb", mem_to_wb_bus, 136'd0);
    chk("arst_rf", {32'd0, mem_to_rf_bus}, 136'd0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_arst_stall", {135'd0, stallreq_for_mem}, 136'd0);

    // Random mix of loads, stores and ALU ops
    for (int i = 0; i < 60; i++) begin
      hilo = {2'($urandom), 32'($urandom), 32'($urandom)};
      res  = $urandom;
      kind = int'($urandom_range(0, 3));
      if (kind <= 1)
        run_instr("rnd_load", hilo, $urandom, 1'b1, 4'h0, 1'($urandom), 1'($urandom),
                  5'($urandom), res, 3'($urandom), $urandom,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      else if (kind == 2)
        run_instr("rnd_store", hilo, $urandom, 1'b1, 4'($urandom_range(1, 15)), 1'b0,
                  1'b0, 5'($urandom), res, 3'($urandom), $urandom, 0, 0);
      else
        run_instr("rnd_alu", hilo, $urandom, 1'b0, 4'($urandom), 1'b0, 1'($urandom),
                  5'($urandom), res, 3'($urandom), $urandom, 0, int'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
